id_ex_pipe_reg: RTL and testbench

//  Parametrised decode->execute pipeline register with elastic valid/ready handshake.

---
 rtl/id_ex_pipe_reg_pkg.sv | 48 ++++
 rtl/id_ex_pipe_reg_if.sv | 19 +
 rtl/id_ex_pipe_reg_hazard.sv | 29 ++
 rtl/id_ex_pipe_reg.sv | 186 ++++++++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared types for the ID/EX pipeline register slice.
// Control bundle layout, enums and register-index helpers.
package pipe_pkg;

  localparam int XLEN_D   = 32;
  localparam int CTRL_W_D = 12;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic       rd_wren;
    logic       mem_wren;
    wb_sel_e    wb_sel;
    logic       br_un;
    logic [1:0] opa_sel;
    logic       opb_sel;
    alu_op_e    alu_op;
  } ctrl_t;

  // x0 never matches: writes to it are discarded.
  function automatic logic reg_hit(
    input logic       wren,
    input logic [4:0] wrd,
    input logic [4:0] rs
  );
    return wren & (wrd != REG_ZERO) & (wrd == rs);
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// Decode/execute handshake bundle.
// Master is the pipeline control side, slave the register.
interface id_ex_pipe_reg_if;
  logic flush;
  logic d_valid;
  logic d_ready;
  logic e_valid;
  logic e_ready;

  modport master (
    output flush, d_valid, e_ready,
    input  d_ready, e_valid
  );

  modport slave (
    input  flush, d_valid, e_ready,
    output d_ready, e_valid
  );
endinterface

// File: rtl/id_ex_pipe_reg_hazard.sv
// Load-use interlock detect.
// E-stage load whose rd feeds a D-stage source.
module hazard_unit
  import pipe_pkg::*;
(
  input  logic       i_e_valid,
  input  logic       i_e_is_load,
  input  logic [4:0] i_e_rd,
  input  logic       i_d_valid,
  input  logic       i_rs1_used,
  input  logic [4:0] i_rs1,
  input  logic       i_rs2_used,
  input  logic [4:0] i_rs2,
  output logic       o_hazard
);

  logic ld_live;
  logic hit1;
  logic hit2;

  // Compare the in-flight load destination against decode sources.
  always_comb begin
    ld_live  = i_e_valid & i_e_is_load & i_d_valid;
    hit1     = reg_hit(i_rs1_used, i_e_rd, i_rs1);
    hit2     = reg_hit(i_rs2_used, i_e_rd, i_rs2);
    o_hazard = ld_live & (hit1 | hit2);
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// Decode->execute pipeline register with elastic handshake,
// load-use bubbles, WB bypass, held refresh and perf counters.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_D,
  parameter int CTRL_W = CTRL_W_D,
  parameter int CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_d_valid,
  output logic              o_d_ready,
  input  logic [XLEN-1:0]   i_d_pc,
  input  logic [XLEN-1:0]   i_d_pc4,
  input  logic [4:0]        i_d_rs1_addr,
  input  logic [4:0]        i_d_rs2_addr,
  input  logic [4:0]        i_d_rd_addr,
  input  logic              i_d_rs1_used,
  input  logic              i_d_rs2_used,
  input  logic [XLEN-1:0]   i_d_rs1_data,
  input  logic [XLEN-1:0]   i_d_rs2_data,
  input  logic [XLEN-1:0]   i_d_imm,
  input  logic [CTRL_W-1:0] i_d_ctrl,
  input  logic              i_d_is_load,
  input  logic              i_w_wren,
  input  logic [4:0]        i_w_rd,
  input  logic [XLEN-1:0]   i_w_data,
  output logic              o_e_valid,
  input  logic              i_e_ready,
  output logic [XLEN-1:0]   o_e_pc,
  output logic [XLEN-1:0]   o_e_pc4,
  output logic [XLEN-1:0]   o_e_rs1_data,
  output logic [XLEN-1:0]   o_e_rs2_data,
  output logic [XLEN-1:0]   o_e_imm,
  output logic [4:0]        o_e_rs1_addr,
  output logic [4:0]        o_e_rs2_addr,
  output logic [4:0]        o_e_rd_addr,
  output logic [CTRL_W-1:0] o_e_ctrl,
  output logic              o_e_is_load,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_bubble_cnt
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   pc4_q, pc4_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [4:0]        rs1_addr_q, rs1_addr_d;
  logic [4:0]        rs2_addr_q, rs2_addr_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              is_load_q, is_load_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic            hazard;
  logic            accept;
  logic            bubble;
  logic [XLEN-1:0] byp1;
  logic [XLEN-1:0] byp2;

  hazard_unit u_hazard (
    .i_e_valid   (valid_q),
    .i_e_is_load (is_load_q),
    .i_e_rd      (rd_addr_q),
    .i_d_valid   (i_d_valid),
    .i_rs1_used  (i_d_rs1_used),
    .i_rs1       (i_d_rs1_addr),
    .i_rs2_used  (i_d_rs2_used),
    .i_rs2       (i_d_rs2_addr),
    .o_hazard    (hazard)
  );

  // Handshake and WB->ID operand bypass muxes.
  always_comb begin
    o_d_ready = ~i_flush & ~hazard & (~valid_q | i_e_ready);
    accept    = i_d_valid & o_d_ready;
    bubble    = hazard & i_e_ready;
    byp1 = reg_hit(i_w_wren, i_w_rd, i_d_rs1_addr) ?
           i_w_data : i_d_rs1_data;
    byp2 = reg_hit(i_w_wren, i_w_rd, i_d_rs2_addr) ?
           i_w_data : i_d_rs2_data;
  end

  // Next E-register state: flush > accept > bubble > drain > hold.
  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    pc4_d        = pc4_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    rs1_addr_d   = rs1_addr_q;
    rs2_addr_d   = rs2_addr_q;
    rd_addr_d    = rd_addr_q;
    ctrl_d       = ctrl_q;
    is_load_d    = is_load_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;

    if (i_d_valid & ~o_d_ready)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);

    if (i_flush) begin
      valid_d   = 1'b0;
      ctrl_d    = '0;
      is_load_d = 1'b0;
    end else if (accept) begin
      valid_d    = 1'b1;
      pc_d       = i_d_pc;
      pc4_d      = i_d_pc4;
      rs1_data_d = byp1;
      rs2_data_d = byp2;
      imm_d      = i_d_imm;
      rs1_addr_d = i_d_rs1_addr;
      rs2_addr_d = i_d_rs2_addr;
      rd_addr_d  = i_d_rd_addr;
      ctrl_d     = i_d_ctrl;
      is_load_d  = i_d_is_load;
    end else if (bubble) begin
      valid_d      = 1'b0;
      ctrl_d       = '0;
      is_load_d    = 1'b0;
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else if (valid_q & i_e_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      if (reg_hit(i_w_wren, i_w_rd, rs1_addr_q))
        rs1_data_d = i_w_data;
      if (reg_hit(i_w_wren, i_w_rd, rs2_addr_q))
        rs2_data_d = i_w_data;
    end
  end

  // E register and counters with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      pc4_q        <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      rd_addr_q    <= '0;
      ctrl_q       <= '0;
      is_load_q    <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      pc4_q        <= pc4_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rs1_addr_q   <= rs1_addr_d;
      rs2_addr_q   <= rs2_addr_d;
      rd_addr_q    <= rd_addr_d;
      ctrl_q       <= ctrl_d;
      is_load_q    <= is_load_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign o_e_valid    = valid_q;
  assign o_e_pc       = pc_q;
  assign o_e_pc4      = pc4_q;
  assign o_e_rs1_data = rs1_data_q;
  assign o_e_rs2_data = rs2_data_q;
  assign o_e_imm      = imm_q;
  assign o_e_rs1_addr = rs1_addr_q;
  assign o_e_rs2_addr = rs2_addr_q;
  assign o_e_rd_addr  = rd_addr_q;
  assign o_e_ctrl     = ctrl_q;
  assign o_e_is_load  = is_load_q;
  assign o_stall_cnt  = stall_cnt_q;
  assign o_bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg with a per-cycle
// reference model plus hand-computed checkpoints.
module tb_id_ex_pipe_reg;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_pipe_reg_if bus ();

  logic [31:0] d_pc, d_pc4, d_rs1_data, d_rs2_data, d_imm;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic        d_rs1_used, d_rs2_used, d_is_load;
  logic [11:0] d_ctrl;
  logic        w_wren;
  logic [4:0]  w_rd;
  logic [31:0] w_data;

  logic [31:0] e_pc, e_pc4, e_rs1_data, e_rs2_data, e_imm;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic [11:0] e_ctrl;
  logic        e_is_load;
  logic [31:0] stall_cnt, bubble_cnt;

  id_ex_pipe_reg dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_flush      (bus.flush),
    .i_d_valid    (bus.d_valid),
    .o_d_ready    (bus.d_ready),
    .i_d_pc       (d_pc),
    .i_d_pc4      (d_pc4),
    .i_d_rs1_addr (d_rs1),
    .i_d_rs2_addr (d_rs2),
    .i_d_rd_addr  (d_rd),
    .i_d_rs1_used (d_rs1_used),
    .i_d_rs2_used (d_rs2_used),
    .i_d_rs1_data (d_rs1_data),
    .i_d_rs2_data (d_rs2_data),
    .i_d_imm      (d_imm),
    .i_d_ctrl     (d_ctrl),
    .i_d_is_load  (d_is_load),
    .i_w_wren     (w_wren),
    .i_w_rd       (w_rd),
    .i_w_data     (w_data),
    .o_e_valid    (bus.e_valid),
    .i_e_ready    (bus.e_ready),
    .o_e_pc       (e_pc),
    .o_e_pc4      (e_pc4),
    .o_e_rs1_data (e_rs1_data),
    .o_e_rs2_data (e_rs2_data),
    .o_e_imm      (e_imm),
    .o_e_rs1_addr (e_rs1),
    .o_e_rs2_addr (e_rs2),
    .o_e_rd_addr  (e_rd),
    .o_e_ctrl     (e_ctrl),
    .o_e_is_load  (e_is_load),
    .o_stall_cnt  (stall_cnt),
    .o_bubble_cnt (bubble_cnt)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h",
                  nm, act, exp);
  endtask

  // Reference model: the E slot as an instruction record.
  logic        m_valid = 0;
  logic [31:0] m_pc = 0, m_pc4 = 0, m_imm = 0;
  logic [31:0] m_op1 = 0, m_op2 = 0;
  logic [4:0]  m_rs1 = 0, m_rs2 = 0, m_rd = 0;
  logic [11:0] m_ctrl = 0;
  logic        m_ld = 0;
  logic [31:0] m_stall = 0, m_bub = 0;

  function automatic logic wb_fwd(input logic [4:0] r);
    return w_wren && w_rd != 0 && w_rd == r;
  endfunction

  function automatic logic m_load_use();
    logic uses;
    uses = (d_rs1_used && d_rs1 == m_rd) ||
           (d_rs2_used && d_rs2 == m_rd);
    return m_valid && m_ld && m_rd != 0 &&
           bus.d_valid && uses;
  endfunction

  function automatic logic m_ready();
    if (bus.flush) return 1'b0;
    if (m_load_use()) return 1'b0;
    return !m_valid || bus.e_ready;
  endfunction

  always @(posedge clk) begin
    logic lu, rdy;
    lu  = m_load_use();
    rdy = m_ready();
    if (rst) begin
      m_valid = 0; m_pc = 0; m_pc4 = 0; m_imm = 0;
      m_op1 = 0; m_op2 = 0; m_rs1 = 0; m_rs2 = 0;
      m_rd = 0; m_ctrl = 0; m_ld = 0;
      m_stall = 0; m_bub = 0;
    end else begin
      if (bus.d_valid && !rdy) m_stall = m_stall + 1;
      if (bus.flush) begin
        m_valid = 0; m_ctrl = 0; m_ld = 0;
      end else if (bus.d_valid && rdy) begin
        m_valid = 1; m_pc = d_pc; m_pc4 = d_pc4;
        m_imm = d_imm; m_rs1 = d_rs1; m_rs2 = d_rs2;
        m_rd = d_rd; m_ctrl = d_ctrl; m_ld = d_is_load;
        m_op1 = wb_fwd(d_rs1) ? w_data : d_rs1_data;
        m_op2 = wb_fwd(d_rs2) ? w_data : d_rs2_data;
      end else if (lu && bus.e_ready) begin
        m_valid = 0; m_ctrl = 0; m_ld = 0;
        m_bub = m_bub + 1;
      end else if (m_valid && bus.e_ready) begin
        m_valid = 0;
      end else if (m_valid) begin
        if (wb_fwd(m_rs1)) m_op1 = w_data;
        if (wb_fwd(m_rs2)) m_op2 = w_data;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    #2;
    chk("d_ready", 64'(bus.d_ready), 64'(m_ready()));
    chk("e_valid", 64'(bus.e_valid), 64'(m_valid));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
    if (m_valid) begin
      chk("pc", 64'(e_pc), 64'(m_pc));
      chk("pc4", 64'(e_pc4), 64'(m_pc4));
      chk("rs1_data", 64'(e_rs1_data), 64'(m_op1));
      chk("rs2_data", 64'(e_rs2_data), 64'(m_op2));
      chk("imm", 64'(e_imm), 64'(m_imm));
      chk("addrs", {e_rs1, e_rs2, e_rd},
          {m_rs1, m_rs2, m_rd});
      chk("ctrl", 64'(e_ctrl), 64'(m_ctrl));
      chk("is_load", 64'(e_is_load), 64'(m_ld));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic instr(input logic [31:0] pc,
                       input logic [4:0] rs1,
                       input logic u1,
                       input logic [4:0] rs2,
                       input logic u2,
                       input logic [4:0] rd,
                       input logic ld);
    ctrl_t c;
    c = '{rd_wren: 1'b1, mem_wren: 1'b0,
          wb_sel: ld ? WB_MEM : WB_ALU, br_un: 1'b0,
          opa_sel: 2'd0, opb_sel: 1'b0, alu_op: ALU_ADD};
    bus.d_valid = 1; d_pc = pc; d_pc4 = pc + 4;
    d_rs1 = rs1; d_rs1_used = u1;
    d_rs2 = rs2; d_rs2_used = u2;
    d_rd = rd; d_is_load = ld; d_ctrl = c;
    d_imm = pc ^ 32'hA5A5_0000;
    d_rs1_data = 32'h1000 + 32'(rs1);
    d_rs2_data = 32'h2000 + 32'(rs2);
  endtask

  initial begin
    rst = 1; bus.flush = 0; bus.d_valid = 0;
    bus.e_ready = 1;
    d_pc = 0; d_pc4 = 0; d_rs1 = 0; d_rs2 = 0; d_rd = 0;
    d_rs1_used = 0; d_rs2_used = 0; d_is_load = 0;
    d_rs1_data = 0; d_rs2_data = 0; d_imm = 0; d_ctrl = 0;
    w_wren = 0; w_rd = 0; w_data = 0;

    repeat (2) tick();
    chk("rst_valid", 64'(bus.e_valid), 64'h0);
    chk("rst_pc", 64'(e_pc), 64'h0);
    chk("rst_stall", 64'(stall_cnt), 64'h0);
    chk("rst_bubble", 64'(bubble_cnt), 64'h0);
    rst = 0;

    for (int i = 0; i < 3; i++) begin
      instr(32'(4 * i), 5'd1, 1, 5'd2, 1, 5'd3, 0);
      tick();
      chk("b2b_pc", 64'(e_pc), 64'(4 * i));
      chk("b2b_valid", 64'(bus.e_valid), 64'h1);
    end

    instr(32'h10, 5'd2, 1, 5'd0, 0, 5'd5, 1);
    tick();
    instr(32'h14, 5'd5, 1, 5'd1, 1, 5'd6, 0);
    #1 chk("lu_ready", 64'(bus.d_ready), 64'h0);
    tick();
    chk("lu_valid", 64'(bus.e_valid), 64'h0);
    chk("lu_ctrl", 64'(e_ctrl), 64'h0);
    chk("lu_bubble", 64'(bubble_cnt), 64'h1);
    chk("lu_stall", 64'(stall_cnt), 64'h1);
    #1 chk("lu_ready2", 64'(bus.d_ready), 64'h1);
    tick();
    chk("lu_add_pc", 64'(e_pc), 64'h14);
    chk("lu_add_rd", 64'(e_rd), 64'h6);
    bus.d_valid = 0;
    tick();
    chk("drain", 64'(bus.e_valid), 64'h0);

    instr(32'h20, 5'd7, 1, 5'd0, 0, 5'd8, 0);
    w_wren = 1; w_rd = 5'd7; w_data = 32'hDEAD_BEEF;
    tick();
    chk("byp_rs1", 64'(e_rs1_data), 64'hDEAD_BEEF);
    instr(32'h24, 5'd0, 1, 5'd0, 0, 5'd8, 0);
    d_rs1_data = 32'h123;
    w_rd = 5'd0; w_data = 32'hFFFF_FFFF;
    tick();
    chk("byp_x0", 64'(e_rs1_data), 64'h123);
    w_wren = 0;

    instr(32'h30, 5'd0, 0, 5'd9, 1, 5'd10, 0);
    d_rs2_data = 32'h11;
    tick();
    chk("hold_rs2_0", 64'(e_rs2_data), 64'h11);
    bus.e_ready = 0;
    instr(32'h34, 5'd0, 0, 5'd0, 0, 5'd11, 0);
    tick();
    w_wren = 1; w_rd = 5'd9; w_data = 32'h55;
    tick();
    w_wren = 0;
    tick();
    chk("hold_rs2", 64'(e_rs2_data), 64'h55);
    chk("hold_pc", 64'(e_pc), 64'h30);
    chk("hold_stall", 64'(stall_cnt), 64'h4);
    bus.e_ready = 1;
    tick();
    chk("hold_next", 64'(e_pc), 64'h34);

    instr(32'h40, 5'd0, 0, 5'd0, 0, 5'd5, 1);
    tick();
    instr(32'h44, 5'd5, 1, 5'd0, 0, 5'd12, 0);
    bus.flush = 1;
    tick();
    chk("fl_valid", 64'(bus.e_valid), 64'h0);
    chk("fl_ctrl", 64'(e_ctrl), 64'h0);
    chk("fl_bubble", 64'(bubble_cnt), 64'h1);
    chk("fl_stall", 64'(stall_cnt), 64'h5);
    bus.flush = 0;
    tick();
    chk("fl_next", 64'(e_pc), 64'h44);

    bus.e_ready = 0;
    instr(32'h48, 5'd1, 1, 5'd2, 1, 5'd13, 0);
    tick();
    chk("pre_rst_stall", 64'(stall_cnt), 64'h6);
    rst = 1;
    tick();
    chk("mrst_valid", 64'(bus.e_valid), 64'h0);
    chk("mrst_stall", 64'(stall_cnt), 64'h0);
    chk("mrst_bubble", 64'(bubble_cnt), 64'h0);
    chk("mrst_pc", 64'(e_pc), 64'h0);
    rst = 0; bus.d_valid = 0; bus.e_ready = 1;
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
